// File: rtl/acc_op_exec.sv
// acc_op_exec: execute stage consuming the operand accumulator's three slots.
// Optional macro ACC_OP_SAT_EN: saturating ADD/SUB/MUL/MAC results.
module acc_op_exec #(
    parameter int MUL_ITERS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_en,
    input  logic [2:0] op_code,
    input  logic [7:0] r0,
    input  logic [7:0] r1,
    input  logic [7:0] r2,
    input  logic       r0_valid,
    input  logic       r1_valid,
    input  logic       r2_valid,
    output logic       busy,
    output logic       done,
    output logic       clear_operands,
    output logic [7:0] result,
    output logic       flag_zero,
    output logic       flag_carry,
    output logic       err_operand
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       va;
        logic       vb;
        logic       vc;
    } opnd_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_MAC = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    localparam logic [3:0] LAST_IT = 4'(MUL_ITERS - 1);
    localparam logic [3:0] MAC_IT  = 4'(MUL_ITERS);

    state_t      state_q, state_d;
    opnd_t       opr_q, opr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplr_q, mplr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        clr_q, clr_d;
    logic [7:0]  res_q, res_d;
    logic        zf_q, zf_d;
    logic        cf_q, cf_d;
    logic        err_q, err_d;

    logic [8:0]  sum9;
    logic [8:0]  diff9;
    logic [15:0] acc_nx;
    logic [15:0] mac_sum;
    logic        missing;
    logic        fin;
    logic        wr;
    logic [7:0]  res_v;
    logic        cy_v;

    always_comb begin
        state_d = state_q;
        opr_d   = opr_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        clr_d   = 1'b0;
        res_d   = res_q;
        zf_d    = zf_q;
        cf_d    = cf_q;
        err_d   = err_q;
        fin     = 1'b0;
        wr      = 1'b0;
        res_v   = res_q;
        cy_v    = cf_q;

        sum9    = {1'b0, opr_q.a} + {1'b0, opr_q.b};
        diff9   = {1'b0, opr_q.a} - {1'b0, opr_q.b};
        acc_nx  = mplr_q[0] ? acc_q + mcand_q : acc_q;
        mac_sum = acc_q + {8'h00, opr_q.c};
        missing = !opr_q.va || !opr_q.vb ||
                  (opr_q.op == OP_MAC && !opr_q.vc);

        unique case (state_q)
            IDLE: begin
                if (op_en) begin
                    opr_d   = '{op: op_code, a: r0, b: r1, c: r2,
                                va: r0_valid, vb: r1_valid, vc: r2_valid};
                    cnt_d   = 4'd0;
                    acc_d   = 16'h0000;
                    mcand_d = {8'h00, r0};
                    mplr_d  = r1;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (missing) begin
                    fin   = 1'b1;
                    err_d = 1'b1;
                end else begin
                    unique case (opr_q.op)
                        OP_ADD: begin
                            wr    = 1'b1;
                            res_v = sum9[7:0];
                            cy_v  = sum9[8];
                        end
                        OP_SUB: begin
                            wr    = 1'b1;
                            res_v = diff9[7:0];
                            cy_v  = diff9[8];
                        end
                        OP_AND: begin
                            wr    = 1'b1;
                            res_v = opr_q.a & opr_q.b;
                            cy_v  = 1'b0;
                        end
                        OP_OR: begin
                            wr    = 1'b1;
                            res_v = opr_q.a | opr_q.b;
                            cy_v  = 1'b0;
                        end
                        OP_XOR: begin
                            wr    = 1'b1;
                            res_v = opr_q.a ^ opr_q.b;
                            cy_v  = 1'b0;
                        end
                        OP_CMP: begin
                            wr    = 1'b1;
                            res_v = {7'h00, opr_q.a < opr_q.b};
                            cy_v  = opr_q.a == opr_q.b;
                        end
                        default: begin
                            // MAC spends one cycle past the last iteration adding r2
                            if (cnt_q == MAC_IT) begin
                                wr    = 1'b1;
                                res_v = mac_sum[7:0];
                                cy_v  = |mac_sum[15:8];
                            end else begin
                                acc_d   = acc_nx;
                                mcand_d = mcand_q << 1;
                                mplr_d  = mplr_q >> 1;
                                cnt_d   = cnt_q + 4'd1;
                                if (cnt_q == LAST_IT && opr_q.op == OP_MUL) begin
                                    wr    = 1'b1;
                                    res_v = acc_nx[7:0];
                                    cy_v  = |acc_nx[15:8];
                                end
                            end
                        end
                    endcase
                    fin = wr;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef ACC_OP_SAT_EN
        if (wr && cy_v) begin
            if (opr_q.op == OP_SUB) begin
                res_v = 8'h00;
            end else if (opr_q.op == OP_ADD || opr_q.op == OP_MUL ||
                         opr_q.op == OP_MAC) begin
                res_v = 8'hFF;
            end
        end
`else
`endif

        if (wr) begin
            res_d = res_v;
            cf_d  = cy_v;
            zf_d  = (res_v == 8'h00);
        end
        if (fin) begin
            state_d = DONE;
            done_d  = 1'b1;
            clr_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opr_q   <= '0;
            cnt_q   <= 4'd0;
            acc_q   <= 16'h0000;
            mcand_q <= 16'h0000;
            mplr_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_q   <= 1'b0;
            res_q   <= 8'h00;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opr_q   <= opr_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            clr_q   <= clr_d;
            res_q   <= res_d;
            zf_q    <= zf_d;
            cf_q    <= cf_d;
            err_q   <= err_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign clear_operands = clr_q;
    assign result         = res_q;
    assign flag_zero      = zf_q;
    assign flag_carry     = cf_q;
    assign err_operand    = err_q;

endmodule

// File: tb/tb_acc_op_exec.sv
// tb_acc_op_exec: vector table, random ops against an arithmetic model,
// held op_en and mid-operation reset sequences.
module tb_acc_op_exec;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_en = 1'b0;
    logic [2:0] op_code = 3'd0;
    logic [7:0] r0 = 8'h00;
    logic [7:0] r1 = 8'h00;
    logic [7:0] r2 = 8'h00;
    logic       r0_valid = 1'b0;
    logic       r1_valid = 1'b0;
    logic       r2_valid = 1'b0;
    logic       busy;
    logic       done;
    logic       clear_operands;
    logic [7:0] result;
    logic       flag_zero;
    logic       flag_carry;
    logic       err_operand;

    acc_op_exec dut (
        .clk(clk),
        .rst_n(rst_n),
        .op_en(op_en),
        .op_code(op_code),
        .r0(r0),
        .r1(r1),
        .r2(r2),
        .r0_valid(r0_valid),
        .r1_valid(r1_valid),
        .r2_valid(r2_valid),
        .busy(busy),
        .done(done),
        .clear_operands(clear_operands),
        .result(result),
        .flag_zero(flag_zero),
        .flag_carry(flag_carry),
        .err_operand(err_operand)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [2:0] v;
        logic [7:0] res;
        logic       cy;
        logic       z;
        logic       err;
        int         lat;
    } vec_t;

    int total = 0;
    int bad = 0;
    logic [7:0] pr = 8'h00;
    logic       pc = 1'b0;
    logic       pz = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] c,
                                input logic [2:0] v, input logic [7:0] res,
                                input logic cy, input logic z,
                                input logic err, input int lat);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.c = c; t.v = v;
        t.res = res; t.cy = cy; t.z = z; t.err = err; t.lat = lat;
        return t;
    endfunction

    // Arithmetic reference: results from plain integer math
    function automatic vec_t model(input logic [2:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic [7:0] c,
                                   input logic [2:0] v);
        vec_t e;
        int ia, ib, ic, s;
        ia = int'(a); ib = int'(b); ic = int'(c);
        e = mk(op, a, b, c, v, pr, pc, pz, 1'b0, 2);
        if (!v[0] || !v[1] || (op == 3'd6 && !v[2])) begin
            e.err = 1'b1;
            return e;
        end
        case (op)
            3'd0: begin s = ia + ib; e.cy = s > 255; e.res = 8'(s); end
            3'd1: begin s = ia - ib; e.cy = ia < ib; e.res = 8'(s); end
            3'd2: begin e.res = a & b; e.cy = 1'b0; end
            3'd3: begin e.res = a | b; e.cy = 1'b0; end
            3'd4: begin e.res = a ^ b; e.cy = 1'b0; end
            3'd5: begin s = ia * ib; e.cy = s > 255; e.res = 8'(s); e.lat = 9; end
            3'd6: begin s = ia * ib + ic; e.cy = s > 255; e.res = 8'(s); e.lat = 10; end
            default: begin e.res = (ia < ib) ? 8'h01 : 8'h00; e.cy = ia == ib; end
        endcase
`ifdef ACC_OP_SAT_EN
        if (e.cy && op == 3'd1) e.res = 8'h00;
        else if (e.cy && (op == 3'd0 || op == 3'd5 || op == 3'd6)) e.res = 8'hFF;
`endif
        e.z = (e.res == 8'h00);
        return e;
    endfunction

    task automatic do_op(input vec_t t, input string tag);
        int n;
        bit busy_ok;
        @(negedge clk);
        op_code = t.op; r0 = t.a; r1 = t.b; r2 = t.c;
        {r2_valid, r1_valid, r0_valid} = t.v;
        op_en = 1'b1;
        @(posedge clk); #1;
        op_en = 1'b0;
        r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
        {r2_valid, r1_valid, r0_valid} = 3'($urandom);
        n = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " lat"}, n + 1, t.lat);
        chk({tag, " busy"}, {busy_ok, busy}, 2'b11);
        chk({tag, " clr"}, clear_operands, 1'b1);
        chk({tag, " res"}, result, t.res);
        chk({tag, " carry"}, flag_carry, t.cy);
        chk({tag, " zero"}, flag_zero, t.z);
        chk({tag, " err"}, err_operand, t.err);
        @(posedge clk); #1;
        chk({tag, " end"}, {busy, done, clear_operands}, 3'b000);
        pr = t.res; pc = t.cy; pz = t.z;
    endtask

    vec_t tbl[12];
    vec_t e;

    initial begin
        int n, ndone;
        bit seen;

        tbl[0]  = mk(3'd0, 8'd200, 8'd100, 8'd0, 3'b111, 8'h2C, 1'b1, 1'b0, 1'b0, 2);
        tbl[1]  = mk(3'd1, 8'd5, 8'd9, 8'd0, 3'b011, 8'hFC, 1'b1, 1'b0, 1'b0, 2);
        tbl[2]  = mk(3'd7, 8'd7, 8'd7, 8'd0, 3'b011, 8'h00, 1'b1, 1'b1, 1'b0, 2);
        tbl[3]  = mk(3'd5, 8'd13, 8'd20, 8'd0, 3'b011, 8'h04, 1'b1, 1'b0, 1'b0, 9);
        tbl[4]  = mk(3'd6, 8'd3, 8'd4, 8'd5, 3'b111, 8'h11, 1'b0, 1'b0, 1'b0, 10);
        tbl[5]  = mk(3'd0, 8'd1, 8'd2, 8'd0, 3'b101, 8'h11, 1'b0, 1'b0, 1'b1, 2);
        tbl[6]  = mk(3'd2, 8'hF0, 8'h3C, 8'd0, 3'b011, 8'h30, 1'b0, 1'b0, 1'b0, 2);
        tbl[7]  = mk(3'd4, 8'hAA, 8'hAA, 8'd0, 3'b011, 8'h00, 1'b0, 1'b1, 1'b0, 2);
        tbl[8]  = mk(3'd3, 8'h0F, 8'h30, 8'd0, 3'b011, 8'h3F, 1'b0, 1'b0, 1'b0, 2);
        tbl[9]  = mk(3'd7, 8'd3, 8'd9, 8'd0, 3'b011, 8'h01, 1'b0, 1'b0, 1'b0, 2);
        tbl[10] = mk(3'd6, 8'd3, 8'd4, 8'd5, 3'b011, 8'h01, 1'b0, 1'b0, 1'b1, 2);
        tbl[11] = mk(3'd5, 8'd255, 8'd255, 8'd0, 3'b011, 8'h01, 1'b1, 1'b0, 1'b0, 9);
`ifdef ACC_OP_SAT_EN
        tbl[0].res = 8'hFF;
        tbl[1].res = 8'h00; tbl[1].z = 1'b1;
        tbl[3].res = 8'hFF;
        tbl[11].res = 8'hFF;
`endif

        #12;
        chk("reset outputs", {busy, done, clear_operands, result,
                              flag_zero, flag_carry, err_operand}, 14'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 150; i++) begin
            e = model(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                      8'($urandom),
                      ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b111);
            do_op(e, $sformatf("rnd%0d", i));
        end

        // op_en held high across a MUL, then a follow-on ADD
        e = model(3'd5, 8'd13, 8'd20, 8'd0, 3'b111);
        @(negedge clk);
        op_code = 3'd5; r0 = 8'd13; r1 = 8'd20; r2 = 8'd0;
        {r2_valid, r1_valid, r0_valid} = 3'b111;
        op_en = 1'b1;
        @(posedge clk); #1;
        n = 0;
        ndone = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) ndone++;
        end
        chk("hold lat", n + 1, e.lat);
        chk("hold res", result, e.res);
        op_code = 3'd0; r0 = 8'd1; r1 = 8'd2;
        @(posedge clk); #1;
        chk("hold idle", {busy, done}, 2'b00);
        chk("hold ndone", ndone, 1);
        @(posedge clk); #1;
        chk("hold accept", {busy, done}, 2'b10);
        op_en = 1'b0;
        @(posedge clk); #1;
        chk("hold 2nd done", {done, clear_operands, result}, {2'b11, 8'h03});
        @(posedge clk); #1;
        chk("hold 2nd end", {busy, done}, 2'b00);

        // reset during MUL iterations
        @(negedge clk);
        op_code = 3'd5; r0 = 8'd13; r1 = 8'd20;
        {r2_valid, r1_valid, r0_valid} = 3'b011;
        op_en = 1'b1;
        @(posedge clk); #1;
        op_en = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("pre-rst busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async rst", {busy, done, clear_operands, result,
                          flag_zero, flag_carry, err_operand}, 14'h0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1 || clear_operands === 1'b1) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (done === 1'b1 || clear_operands === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        chk("rst no done", seen, 1'b0);
        pr = 8'h00; pc = 1'b0; pz = 1'b0;
        e = model(3'd0, 8'd1, 8'd2, 8'd0, 3'b011);
        do_op(e, "post-rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_op_exec.md
Name: acc_op_exec

Overview:
Operand-consuming execute stage directly downstream of the three-slot operand accumulator. On an op request it captures r0/r1/r2 and their valid flags, runs the selected 8-bit operation (single-cycle logic/add or iterative shift-add multiply) and returns an 8-bit result with flags. On completion it pulses clear_operands, which drives the accumulator's opEn so the operand slots are freed for the next instruction.

Parameters:
MUL_ITERS, 8, shift-add iterations for MUL/MAC; equals the operand width and must not be changed.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
op_en  input  1  op request; sampled only in IDLE
op_code  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 MAC, 7 CMP
r0, r1, r2  input  8 each  operand slots from the accumulator
r0_valid, r1_valid, r2_valid  input  1 each  operand valid flags
busy  output  1  high from the capture edge until done
done  output  1  one-cycle completion pulse
clear_operands  output  1  one-cycle pulse, coincident with done (also on error)
result  output  8  registered result
flag_zero  output  1  result == 0
flag_carry  output  1  carry / borrow / overflow, per op
err_operand  output  1  required operand missing; valid while done=1

Behaviour:
- Reset (async, rst_n low): state=IDLE; busy, done, clear_operands, result, flag_zero, flag_carry, err_operand, counter and operand latches all 0.
- States: IDLE, EXEC, DONE.
- IDLE: op_en=1 at edge E0 -> latch op_code, r0..r2 and valid flags; busy=1; go to EXEC. op_en while not IDLE is ignored and not queued.
- Required operands: r0 and r1 for every op; r2 additionally for MAC. If any is missing, EXEC is skipped: go straight to DONE with err_operand=1. result and flags hold their previous values.
- Single-cycle ops (0-4, 7): EXEC computes at E1 and goes to DONE. done and clear_operands are high in the cycle after E1, and busy drops at E2. Latency is op_en-sample edge to done = 2 cycles.
- ADD: result = (r0+r1)[7:0]; carry = bit 8 of the sum.
- SUB: result = (r0-r1)[7:0]; carry = borrow (r0<r1).
- AND, OR, XOR: carry = 0.
- CMP: result = 8'h01 if r0<r1 (unsigned), else 8'h00; carry = (r0==r1).
- MUL: 16-bit accumulator, multiplier shifted right once per cycle, 4-bit counter counts MUL_ITERS cycles. result = product[7:0]; carry = |product[15:8]. done is 9 cycles after the sample edge.
- MAC: after the MUL iterations, one extra cycle adds r2 to the 16-bit product. result = sum[7:0]; carry = |sum[15:8]. done is 10 cycles after the sample edge.
- flag_zero = (result == 0), updated together with result. Flags are unchanged on an error completion.
- DONE: lasts exactly one cycle, then IDLE; busy falls on the same edge. A new op_en is accepted at the earliest on the first IDLE edge.
- Operand inputs changing after capture have no effect on an in-flight op.
- rst_n asserted mid-op aborts immediately to reset values: no done, no clear_operands.

Optional Feature:
ACC_OP_SAT_EN
- Defined: ADD, MUL and MAC saturate to 8'hFF when carry=1; SUB saturates to 8'h00 when borrow=1. flag_carry still reports the overflow.
- Undefined: all ops wrap modulo 256, as specified above.

Test Plan:
- ADD 200+100, all valid -> done 2 cycles after op_en; result=8'h2C, carry=1, zero=0, clear_operands pulses once with done.
- SUB 5-9 -> result=8'hFC, carry=1. CMP 7 vs 7 -> result=8'h00, carry=1.
- MUL 13*20 -> busy for 9 cycles; result=8'h04, carry=1. MAC 3*4+5 -> done at cycle 10; result=8'h11, carry=0, zero=0.
- ADD with r1_valid=0 -> done at cycle 2 with err_operand=1; result and flags keep their prior values; clear_operands pulses.
- op_en held high through a MUL -> exactly one done; a second op issued on the first IDLE cycle is accepted. rst_n low at MUL cycle 4 -> all outputs 0 asynchronously, no done pulse.
- With ACC_OP_SAT_EN: ADD 200+100 -> 8'hFF, carry=1; SUB 5-9 -> 8'h00, carry=1; MUL 13*20 -> 8'hFF.
